// File: rtl/l2_bank_pkg.sv
// L2 bank controller shared types: response tag, window map mode
// and the address decode helper.
package l2_bank_pkg;

  typedef enum logic [1:0] {
    INTERL,
    NONINTERL,
    MISS
  } map_mode_e;

  localparam int unsigned TagBankW = 8;

  typedef struct packed {
    logic                valid;
    logic [TagBankW-1:0] bank;
    logic                miss;
    logic                write;
  } resp_tag_t;

  typedef struct packed {
    map_mode_e   mode;
    logic [31:0] bank;
    logic [31:0] row;
  } dec_t;

  // Both windows span the whole memory; interleaved puts the
  // bank in the low word-index bits, contiguous in the high ones.
  function automatic dec_t l2_decode(
    input logic [63:0] addr,
    input logic [63:0] ibase,
    input logic [63:0] nbase,
    input int unsigned off_w,
    input int unsigned bank_w,
    input int unsigned row_w
  );
    logic [63:0] span;
    logic [63:0] w;
    dec_t        d;
    span   = 64'd1 << (off_w + bank_w + row_w);
    w      = '0;
    d.mode = MISS;
    d.bank = '0;
    d.row  = '0;
    if (addr >= ibase && (addr - ibase) < span) begin
      w      = (addr - ibase) >> off_w;
      d.mode = INTERL;
      d.bank = 32'(w & ((64'd1 << bank_w) - 64'd1));
      d.row  = 32'(w >> bank_w);
    end else if (addr >= nbase && (addr - nbase) < span) begin
      w      = (addr - nbase) >> off_w;
      d.mode = NONINTERL;
      d.bank = 32'(w >> row_w);
      d.row  = 32'(w & ((64'd1 << row_w) - 64'd1));
    end
    return d;
  endfunction

endpackage

// File: rtl/l2_bank_rr_arb.sv
// Per-bank round-robin arbiter with its own pointer register.
// Ports: clk_i, rst_i, req_i[NumPort] in; gnt_o[NumPort] one-hot out.
module l2_bank_rr_arb
  import l2_bank_pkg::*;
#(
  parameter int unsigned NumPort = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumPort-1:0] req_i,
  output logic [NumPort-1:0] gnt_o
);

  localparam int unsigned PtrW =
    (NumPort > 1) ? $clog2(NumPort) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  int unsigned     idx, win;
  logic            found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    win   = 0;
    idx   = 0;
    for (int unsigned k = 0; k < NumPort; k++) begin
      idx = (32'(ptr_q) + k) % NumPort;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win        = idx;
      end
    end
    ptr_d = found ? PtrW'((win + 1) % NumPort) : ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/l2_bank_ctrl.sv
// Multi-port multi-bank L2 SRAM controller: dual-window decode,
// per-bank RR arbitration, fixed 1-cycle response.
// Ports: req/gnt/addr/we/be/wdata per port in, rvalid/rdata/err out;
// bank_req/we/be/addr/wdata out, bank_rdata/bank_ecc_err in.
// Option L2_BANK_SCRUB_EN adds a background scrubber and
// scrub_err_cnt_o (param ScrubPeriod).
module l2_bank_ctrl
  import l2_bank_pkg::*;
#(
  parameter int unsigned NumPort   = 2,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned BankWords = 4096,
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter logic [AddrWidth-1:0] InterlBase    = 48'h7800_0000,
  parameter logic [AddrWidth-1:0] NonInterlBase = 48'h7802_0000,
`ifdef L2_BANK_SCRUB_EN
  parameter int unsigned ScrubPeriod = 1024,
`endif
  parameter int unsigned RowWidth  = $clog2(BankWords)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumPort-1:0]             req_i,
  output logic [NumPort-1:0]             gnt_o,
  input  logic [NumPort*AddrWidth-1:0]   addr_i,
  input  logic [NumPort-1:0]             we_i,
  input  logic [NumPort*DataWidth/8-1:0] be_i,
  input  logic [NumPort*DataWidth-1:0]   wdata_i,
  output logic [NumPort-1:0]             rvalid_o,
  output logic [NumPort*DataWidth-1:0]   rdata_o,
  output logic [NumPort-1:0]             err_o,
  output logic [NumBanks-1:0]            bank_req_o,
  output logic [NumBanks-1:0]            bank_we_o,
  output logic [NumBanks*DataWidth/8-1:0] bank_be_o,
  output logic [NumBanks*RowWidth-1:0]   bank_addr_o,
  output logic [NumBanks*DataWidth-1:0]  bank_wdata_o,
  input  logic [NumBanks*DataWidth-1:0]  bank_rdata_i,
  input  logic [NumBanks-1:0]            bank_ecc_err_i
`ifdef L2_BANK_SCRUB_EN
  ,
  output logic [15:0]                    scrub_err_cnt_o
`endif
);

  localparam int unsigned Bw       = DataWidth / 8;
  localparam int unsigned OffW     = $clog2(Bw);
  localparam int unsigned BankBits = $clog2(NumBanks);
  localparam int unsigned BankW    = (BankBits > 0) ? BankBits : 1;

  logic [BankW-1:0]    pbank [NumPort];
  logic [RowWidth-1:0] prow  [NumPort];
  logic [NumPort-1:0]  pmiss;
  logic [NumPort-1:0]  phit;
  logic [NumPort-1:0]  breq  [NumBanks];
  logic [NumPort-1:0]  bgnt  [NumBanks];
  resp_tag_t           tag_q [NumPort];
  resp_tag_t           tag_d [NumPort];
  logic [63:0]         a64;
  dec_t                dec;

  always_comb begin
    a64 = '0;
    dec = '0;
    for (int p = 0; p < NumPort; p++) begin
      a64 = '0;
      a64[AddrWidth-1:0] = addr_i[p*AddrWidth +: AddrWidth];
      dec = l2_decode(a64, 64'(InterlBase), 64'(NonInterlBase),
                      OffW, BankBits, RowWidth);
      pbank[p] = dec.bank[BankW-1:0];
      prow[p]  = dec.row[RowWidth-1:0];
      pmiss[p] = (dec.mode == MISS);
    end
  end

  always_comb begin
    for (int b = 0; b < NumBanks; b++)
      for (int p = 0; p < NumPort; p++)
        breq[b][p] = req_i[p] & ~pmiss[p] &
                     (32'(pbank[p]) == b);
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_arb
    l2_bank_rr_arb #(.NumPort(NumPort)) u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (breq[b]),
      .gnt_o (bgnt[b])
    );
  end

  // Misses never touch a bank, so they are granted unconditionally.
  always_comb begin
    phit = '0;
    for (int p = 0; p < NumPort; p++) begin
      for (int b = 0; b < NumBanks; b++)
        phit[p] = phit[p] | bgnt[b][p];
      gnt_o[p] = ~rst_i & req_i[p] & (pmiss[p] | phit[p]);
    end
  end

`ifdef L2_BANK_SCRUB_EN
  localparam int unsigned PerW =
    (ScrubPeriod > 1) ? $clog2(ScrubPeriod) : 1;

  logic [PerW-1:0]     per_q, per_d;
  logic                pend_q, pend_d;
  logic [BankW-1:0]    sbank_q, sbank_d;
  logic [RowWidth-1:0] srow_q, srow_d;
  logic                chk_q, chk_d;
  logic [BankW-1:0]    cbank_q, cbank_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                scrub_fire;

  // The scrubber only steals idle bank cycles; arbiters never see it.
  always_comb begin
    scrub_fire = pend_q & ~rst_i & ~(|breq[sbank_q]);
    per_d   = (per_q == PerW'(ScrubPeriod - 1)) ? '0 : per_q + 1'b1;
    pend_d  = pend_q;
    sbank_d = sbank_q;
    srow_d  = srow_q;
    if (scrub_fire) begin
      pend_d = 1'b0;
      if (sbank_q == BankW'(NumBanks - 1)) begin
        sbank_d = '0;
        srow_d  = srow_q + 1'b1;
      end else begin
        sbank_d = sbank_q + 1'b1;
      end
    end
    if (per_q == PerW'(ScrubPeriod - 1)) pend_d = 1'b1;
    chk_d   = scrub_fire;
    cbank_d = sbank_q;
    cnt_d   = cnt_q;
    if (chk_q && bank_ecc_err_i[cbank_q] && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      per_q   <= '0;
      pend_q  <= 1'b0;
      sbank_q <= '0;
      srow_q  <= '0;
      chk_q   <= 1'b0;
      cbank_q <= '0;
      cnt_q   <= '0;
    end else begin
      per_q   <= per_d;
      pend_q  <= pend_d;
      sbank_q <= sbank_d;
      srow_q  <= srow_d;
      chk_q   <= chk_d;
      cbank_q <= cbank_d;
      cnt_q   <= cnt_d;
    end
  end

  assign scrub_err_cnt_o = cnt_q;
`endif

  always_comb begin
    bank_req_o   = '0;
    bank_we_o    = '0;
    bank_be_o    = '0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    for (int b = 0; b < NumBanks; b++) begin
      for (int p = 0; p < NumPort; p++) begin
        if (bgnt[b][p] && !rst_i) begin
          bank_req_o[b] = 1'b1;
          bank_we_o[b]  = we_i[p];
          bank_be_o[b*Bw +: Bw] = be_i[p*Bw +: Bw];
          bank_addr_o[b*RowWidth +: RowWidth] = prow[p];
          bank_wdata_o[b*DataWidth +: DataWidth] =
            wdata_i[p*DataWidth +: DataWidth];
        end
      end
`ifdef L2_BANK_SCRUB_EN
      if (scrub_fire && 32'(sbank_q) == b) begin
        bank_req_o[b] = 1'b1;
        bank_be_o[b*Bw +: Bw] = '1;
        bank_addr_o[b*RowWidth +: RowWidth] = srow_q;
      end
`endif
    end
  end

  always_comb begin
    for (int p = 0; p < NumPort; p++)
      tag_d[p] = '{valid: gnt_o[p],
                   bank:  TagBankW'(pbank[p]),
                   miss:  pmiss[p],
                   write: we_i[p]};
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPort; p++) begin
      if (rst_i) tag_q[p] <= '0;
      else       tag_q[p] <= tag_d[p];
    end
  end

  // Gating with rst_i drops a response whose grant preceded reset.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    err_o    = '0;
    for (int p = 0; p < NumPort; p++) begin
      rvalid_o[p] = tag_q[p].valid & ~rst_i;
      if (rvalid_o[p]) begin
        if (tag_q[p].miss) begin
          err_o[p] = 1'b1;
        end else if (!tag_q[p].write) begin
          rdata_o[p*DataWidth +: DataWidth] =
            bank_rdata_i[32'(tag_q[p].bank)*DataWidth +: DataWidth];
          err_o[p] = bank_ecc_err_i[tag_q[p].bank];
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_bank_ctrl.sv
// Directed self-checking bench for l2_bank_ctrl (default parameters).
module tb_l2_bank_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req, we;
  logic [95:0]  addr;
  logic [15:0]  be;
  logic [127:0] wdata;
  logic [1:0]   gnt, rvalid, err;
  logic [127:0] rdata;
  logic [3:0]   bank_req, bank_we, bank_ecc;
  logic [31:0]  bank_be;
  logic [47:0]  bank_addr;
  logic [255:0] bank_wdata, bank_rdata;
`ifdef L2_BANK_SCRUB_EN
  logic [15:0]  scrub_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef L2_BANK_SCRUB_EN
  l2_bank_ctrl #(.ScrubPeriod(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .gnt_o          (gnt),
    .addr_i         (addr),
    .we_i           (we),
    .be_i           (be),
    .wdata_i        (wdata),
    .rvalid_o       (rvalid),
    .rdata_o        (rdata),
    .err_o          (err),
    .bank_req_o     (bank_req),
    .bank_we_o      (bank_we),
    .bank_be_o      (bank_be),
    .bank_addr_o    (bank_addr),
    .bank_wdata_o   (bank_wdata),
    .bank_rdata_i   (bank_rdata),
    .bank_ecc_err_i (bank_ecc),
    .scrub_err_cnt_o(scrub_cnt)
  );
`else
  l2_bank_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .gnt_o          (gnt),
    .addr_i         (addr),
    .we_i           (we),
    .be_i           (be),
    .wdata_i        (wdata),
    .rvalid_o       (rvalid),
    .rdata_o        (rdata),
    .err_o          (err),
    .bank_req_o     (bank_req),
    .bank_we_o      (bank_we),
    .bank_be_o      (bank_be),
    .bank_addr_o    (bank_addr),
    .bank_wdata_o   (bank_wdata),
    .bank_rdata_i   (bank_rdata),
    .bank_ecc_err_i (bank_ecc)
  );
`endif

  function automatic logic [63:0] bd(input int b);
    return 64'hDA7A_0000_0000_00B0 | 64'(b);
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] gexp [4];
  int         nscr;
  logic [3:0] scr0, scr1;

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0;
    be = '0; wdata = '0; bank_ecc = '0;
    for (int b = 0; b < 4; b++) bank_rdata[b*64 +: 64] = bd(b);
    gexp[0] = 2'b01; gexp[1] = 2'b10;
    gexp[2] = 2'b01; gexp[3] = 2'b10;
    nscr = 0; scr0 = '0; scr1 = '0;

    req = 2'b01;
    addr[47:0] = 48'h7800_0018;
    cyc(); cyc(); #3;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_breq", 64'(bank_req), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", rdata[63:0], 64'd0);
    cyc();
    rst = 1'b0; req = '0;

    req = 2'b01; addr[47:0] = 48'h7800_0018;
    #3;
    chk("rd_gnt", 64'(gnt), 64'b01);
    chk("rd_breq", 64'(bank_req), 64'b1000);
    chk("rd_row", 64'(bank_addr[47:36]), 64'd0);
    chk("rd_we", 64'(bank_we), 64'd0);
    cyc(); req = '0;
    chk("rd_rvalid", 64'(rvalid), 64'b01);
    chk("rd_data", rdata[63:0], bd(3));
    chk("rd_err", 64'(err), 64'd0);

    req = 2'b01; we = 2'b01; addr[47:0] = 48'h7802_8000;
    be[7:0] = 8'h0F; wdata[63:0] = 64'h1122_3344_5566_7788;
    #3;
    chk("wr_gnt", 64'(gnt), 64'b01);
    chk("wr_breq", 64'(bank_req), 64'b0010);
    chk("wr_we", 64'(bank_we), 64'b0010);
    chk("wr_be", 64'(bank_be[15:8]), 64'h0F);
    chk("wr_wdata", bank_wdata[127:64], 64'h1122_3344_5566_7788);
    chk("wr_row", 64'(bank_addr[23:12]), 64'd0);
    cyc(); req = '0; we = '0;
    chk("wr_rvalid", 64'(rvalid), 64'b01);
    chk("wr_rdata", rdata[63:0], 64'd0);
    chk("wr_err", 64'(err), 64'd0);

    req = 2'b11;
    addr[47:0] = 48'h7800_0000; addr[95:48] = 48'h7800_0020;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("rr_gnt", 64'(gnt), 64'(gexp[i]));
      chk("rr_row", 64'(bank_addr[11:0]),
          (gexp[i] == 2'b01) ? 64'd0 : 64'd1);
      cyc();
      chk("rr_rvalid", 64'(rvalid), 64'(gexp[i]));
    end
    req = '0;

    req = 2'b11;
    addr[47:0] = 48'h7800_0010; addr[95:48] = 48'h7800_0008;
    #3;
    chk("par_gnt", 64'(gnt), 64'b11);
    chk("par_breq", 64'(bank_req), 64'b0110);
    cyc(); req = '0;
    chk("par_rvalid", 64'(rvalid), 64'b11);
    chk("par_d0", rdata[63:0], bd(2));
    chk("par_d1", rdata[127:64], bd(1));

    req = 2'b01; addr[47:0] = 48'h7804_0000;
    #3;
    chk("miss_gnt", 64'(gnt), 64'b01);
    chk("miss_breq", 64'(bank_req), 64'd0);
    cyc(); req = '0;
    chk("miss_rvalid", 64'(rvalid), 64'b01);
    chk("miss_err", 64'(err), 64'b01);
    chk("miss_rdata", rdata[63:0], 64'd0);
    req = 2'b01; addr[47:0] = 48'h77FF_FFF8;
    #3;
    chk("miss_lo_gnt", 64'(gnt), 64'b01);
    chk("miss_lo_breq", 64'(bank_req), 64'd0);
    cyc(); req = '0;

    bank_ecc = 4'b1000;
    req = 2'b01; addr[47:0] = 48'h7800_0018;
    #3;
    cyc(); req = '0;
    chk("ecc_rvalid", 64'(rvalid), 64'b01);
    chk("ecc_err", 64'(err), 64'b01);
    bank_ecc = '0;

    req = 2'b01; addr[47:0] = 48'h7801_FFF8;
    #3;
    chk("ilast_breq", 64'(bank_req), 64'b1000);
    chk("ilast_row", 64'(bank_addr[47:36]), 64'hFFF);
    cyc();
    addr[47:0] = 48'h7803_FFF8;
    #3;
    chk("nlast_breq", 64'(bank_req), 64'b1000);
    chk("nlast_row", 64'(bank_addr[47:36]), 64'hFFF);
    cyc();
    addr[47:0] = 48'h7802_0000;
    #3;
    chk("nfirst_breq", 64'(bank_req), 64'b0001);
    chk("nfirst_row", 64'(bank_addr[11:0]), 64'd0);
    cyc(); req = '0;

    req = 2'b01; addr[47:0] = 48'h7800_0000;
    #3;
    chk("pre_rst_gnt", 64'(gnt), 64'b01);
    cyc(); req = '0; rst = 1'b1;
    #3;
    chk("rst_drop", 64'(rvalid), 64'd0);
    cyc(); rst = 1'b0;
    #3;
    chk("post_rst_rvalid", 64'(rvalid), 64'd0);
    req = 2'b11;
    addr[47:0] = 48'h7800_0000; addr[95:48] = 48'h7800_0020;
    #1;
    chk("rr_ptr_reset", 64'(gnt), 64'b01);
    cyc(); req = '0;

`ifdef L2_BANK_SCRUB_EN
    bank_ecc = 4'b0001;
    rst = 1'b1;
    cyc(); rst = 1'b0;
    for (int c = 0; c < 32; c++) begin
      #3;
      if (bank_req != 4'b0000) begin
        if (nscr == 0) scr0 = bank_req;
        if (nscr == 1) scr1 = bank_req;
        nscr++;
      end
      cyc();
    end
    chk("scrub_n", 64'(nscr), 64'd3);
    chk("scrub_b0", 64'(scr0), 64'b0001);
    chk("scrub_b1", 64'(scr1), 64'b0010);
    chk("scrub_cnt", 64'(scrub_cnt), 64'd1);
    bank_ecc = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
